esfa_run_sequencer: RTL and testbench

Batch controller for the ESFA engine. Accepts a host command to execute N back-to-back trials and drives the engine's `doRun`/`isRunning`/`didRun` handshake for each one. Enforces a per-trial watchdog, accumulates pass/fail/timeout statistics and latches the first failing instruction. Sits between the host command decoder inside the sandbox process and the ESFA top level, replacing direct one-shot `doRun` control.

---
 rtl/esfa_pkg.sv | 6 +
 rtl/sat_counter.sv | 14 +
 rtl/esfa_run_sequencer.sv | 129 ++++++++++++
 tb/tb_esfa_run_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/esfa_pkg.sv
// esfa_pkg: shared types and defaults for the ESFA run sequencer.
package esfa_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE, RECORD, GAP} runState_t;
  typedef enum logic [1:0] {OP_START = 2'd0, OP_ABORT = 2'd1, OP_CLEAR = 2'd2, OP_RSVD = 2'd3} cmdOp_t;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1048576;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             masterClock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge masterClock)
    if (!reset || clr) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/esfa_run_sequencer.sv
// esfa_run_sequencer: batch trial controller driving the ESFA doRun/isRunning/didRun handshake.
module esfa_run_sequencer
  import esfa_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int COUNT_W        = 16,
  parameter int GAP_CYCLES     = 4
) (
  input  logic               masterClock,
  input  logic               reset,
  input  logic               cmdValid,
  input  logic [1:0]         cmdOp,
  input  logic [COUNT_W-1:0] cmdCount,
  output logic               cmdReady,
  output logic               doRun,
  input  logic               isRunning,
  input  logic               didRun,
  input  logic               wasSuccessful,
  input  logic [31:0]        instructionOfError,
  output logic               busy,
  output logic               batchDone,
  output logic [COUNT_W-1:0] runsDone,
  output logic [COUNT_W-1:0] passCount,
  output logic [COUNT_W-1:0] failCount,
  output logic [COUNT_W-1:0] timeoutCount,
  output logic               firstErrValid,
  output logic [31:0]        firstErrInstr
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  runState_t state, stateNext;
  logic [WD_W-1:0] phaseCount;
  logic [COUNT_W-1:0] remaining;
  logic doRunNext, batchDoneNext, phaseClr, loadBatch, clearStats;
  logic recPass, recFail, recTimeout, trialEnd, abort, expired, gapDone, lastTrial;
  assign cmdReady = (state == IDLE) || (cmdOp == OP_ABORT);
  assign busy = state != IDLE;
  assign abort = cmdValid && cmdOp == OP_ABORT && state != IDLE;
  assign expired = phaseCount == WD_W'(TIMEOUT_CYCLES - 1);
  assign gapDone = phaseCount == WD_W'(GAP_CYCLES - 1);
  assign lastTrial = remaining == COUNT_W'(1);
  assign trialEnd = recPass || recFail || recTimeout;
  always_ff @(posedge masterClock)
    if (!reset) state <= IDLE;
    else state <= stateNext;
  always_comb begin
    stateNext = state;
    doRunNext = 1'b0;
    batchDoneNext = 1'b0;
    phaseClr = 1'b0;
    loadBatch = 1'b0;
    clearStats = 1'b0;
    recPass = 1'b0;
    recFail = 1'b0;
    recTimeout = 1'b0;
    case (state)
      IDLE: begin
        loadBatch = cmdValid && cmdOp == OP_START && cmdCount != '0;
        batchDoneNext = cmdValid && cmdOp == OP_START && cmdCount == '0;
        clearStats = cmdValid && cmdOp == OP_CLEAR;
        stateNext = loadBatch ? LAUNCH : IDLE;
      end
      LAUNCH: begin
        doRunNext = 1'b1;
        phaseClr = 1'b1;
        stateNext = WAIT_START;
      end
      WAIT_START: begin
        phaseClr = isRunning;
        stateNext = isRunning ? WAIT_DONE : WAIT_START;
        recTimeout = !isRunning && expired;
        doRunNext = !isRunning && !expired;
      end
      // completion is checked first so a falling isRunning beats a same-cycle expiry
      WAIT_DONE: begin
        stateNext = isRunning ? WAIT_DONE : RECORD;
        recTimeout = isRunning && expired;
      end
      RECORD: begin
        recPass = didRun && wasSuccessful;
        recFail = !recPass;
      end
      GAP: stateNext = gapDone ? LAUNCH : GAP;
      default: stateNext = IDLE;
    endcase
    if (recPass || recFail || recTimeout) begin
      phaseClr = 1'b1;
      stateNext = lastTrial ? IDLE : GAP;
      batchDoneNext = lastTrial;
    end
    // abort discards whatever trial outcome this cycle would have produced
    if (abort) begin
      stateNext = IDLE;
      doRunNext = 1'b0;
      batchDoneNext = 1'b1;
      recPass = 1'b0;
      recFail = 1'b0;
      recTimeout = 1'b0;
    end
  end
  always_ff @(posedge masterClock)
    if (!reset) begin
      doRun <= 1'b0;
      batchDone <= 1'b0;
      phaseCount <= '0;
      remaining <= '0;
      firstErrValid <= 1'b0;
      firstErrInstr <= '0;
    end else begin
      doRun <= doRunNext;
      batchDone <= batchDoneNext;
      phaseCount <= phaseClr ? '0 : phaseCount + 1'b1;
      remaining <= loadBatch ? cmdCount : trialEnd ? remaining - COUNT_W'(1) : remaining;
      if (clearStats) begin
        firstErrValid <= 1'b0;
        firstErrInstr <= '0;
      end else if (recFail && !firstErrValid) begin
        firstErrValid <= 1'b1;
        firstErrInstr <= instructionOfError;
      end
    end
  sat_counter #(.WIDTH(COUNT_W)) runsCounter (
    .masterClock(masterClock), .reset(reset), .clr(loadBatch), .inc(trialEnd), .count(runsDone));
  sat_counter #(.WIDTH(COUNT_W)) passCounter (
    .masterClock(masterClock), .reset(reset), .clr(clearStats), .inc(recPass), .count(passCount));
  sat_counter #(.WIDTH(COUNT_W)) failCounter (
    .masterClock(masterClock), .reset(reset), .clr(clearStats), .inc(recFail), .count(failCount));
  sat_counter #(.WIDTH(COUNT_W)) timeoutCounter (
    .masterClock(masterClock), .reset(reset), .clr(clearStats), .inc(recTimeout), .count(timeoutCount));
endmodule

// File: tb/tb_esfa_run_sequencer.sv
// tb_esfa_run_sequencer: directed bench with a behavioural engine model and hand-computed expectations.
module tb_esfa_run_sequencer;
  import esfa_pkg::*;
  logic masterClock = 1'b0;
  logic reset = 1'b0;
  logic cmdValid = 1'b0;
  logic [1:0] cmdOp = 2'd0;
  logic [15:0] cmdCount = '0;
  logic cmdReady, doRun, busy, batchDone, firstErrValid;
  logic isRunning = 1'b0;
  logic didRun = 1'b0;
  logic wasSuccessful = 1'b0;
  logic [31:0] instructionOfError = '0;
  logic [15:0] runsDone, passCount, failCount, timeoutCount;
  logic [31:0] firstErrInstr;
  logic engineOn = 1'b0;
  int runLen = 10;
  logic [7:0] failMask = '0;
  logic [31:0] failInstr = '0;
  int batchBase = 0;
  int doRunRises = 0, batchDonePulses = 0, highLen = 0, lastHighLen = 0, lowLen = 0;
  int minLowGap = 1000, left = 0, idx = 0;
  logic prevDoRun = 1'b0, seenRun = 1'b0;
  int vectors = 0, miscompares = 0;
  int riseBase, pulseBase, n;

  always #5 masterClock = ~masterClock;

  esfa_run_sequencer #(.TIMEOUT_CYCLES(16), .COUNT_W(16), .GAP_CYCLES(4)) dut (
    .masterClock(masterClock), .reset(reset), .cmdValid(cmdValid), .cmdOp(cmdOp),
    .cmdCount(cmdCount), .cmdReady(cmdReady), .doRun(doRun), .isRunning(isRunning),
    .didRun(didRun), .wasSuccessful(wasSuccessful), .instructionOfError(instructionOfError),
    .busy(busy), .batchDone(batchDone), .runsDone(runsDone), .passCount(passCount),
    .failCount(failCount), .timeoutCount(timeoutCount), .firstErrValid(firstErrValid),
    .firstErrInstr(firstErrInstr));

  // engine model and activity monitor, both evaluated away from the active edge
  always @(negedge masterClock) begin
    if (doRun && !prevDoRun) begin
      doRunRises++;
      if (seenRun && lowLen < minLowGap) minLowGap = lowLen;
      lowLen = 0;
      seenRun = 1'b1;
    end
    if (doRun) highLen++;
    else begin
      lowLen++;
      if (prevDoRun) begin
        lastHighLen = highLen;
        highLen = 0;
      end
    end
    if (batchDone) batchDonePulses++;
    prevDoRun = doRun;
    if (engineOn && doRun && !isRunning) begin
      isRunning = 1'b1;
      left = runLen;
    end else if (isRunning) begin
      left--;
      if (left == 0) begin
        isRunning = 1'b0;
        didRun = 1'b1;
        idx = doRunRises - batchBase - 1;
        wasSuccessful = !failMask[idx];
        instructionOfError = failMask[idx] ? failInstr : 32'h0;
      end
    end
  end

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic issueCmd(input logic [1:0] op, input logic [15:0] count);
    cmdValid = 1'b1;
    cmdOp = op;
    cmdCount = count;
    @(posedge masterClock);
    #1;
    cmdValid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int k = 0;
    do begin
      @(posedge masterClock);
      #1;
      k++;
    end while (busy && k < 2000);
    checkValue({tag, " idle"}, {31'b0, busy}, 32'd0);
    checkValue({tag, " batchDone"}, {31'b0, batchDone}, 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge masterClock);
    #1;
    checkValue("rst doRun", {31'b0, doRun}, 0);
    checkValue("rst busy", {31'b0, busy}, 0);
    checkValue("rst batchDone", {31'b0, batchDone}, 0);
    checkValue("rst cmdReady", {31'b0, cmdReady}, 1);
    checkValue("rst counters", {16'b0, runsDone | passCount | failCount | timeoutCount}, 0);
    checkValue("rst firstErr", {31'b0, firstErrValid} | firstErrInstr, 0);
    reset = 1'b1;
    @(posedge masterClock);
    #1;
    // three passing trials
    engineOn = 1'b1;
    runLen = 10;
    failMask = 8'h00;
    batchBase = doRunRises;
    riseBase = doRunRises;
    pulseBase = batchDonePulses;
    issueCmd(OP_START, 16'd3);
    checkValue("t1 busy at t+1", {31'b0, busy}, 1);
    checkValue("t1 doRun at t+1", {31'b0, doRun}, 0);
    @(posedge masterClock);
    #1;
    checkValue("t1 doRun at t+2", {31'b0, doRun}, 1);
    waitIdle("t1");
    repeat (3) @(posedge masterClock);
    #1;
    checkValue("t1 passCount", {16'b0, passCount}, 3);
    checkValue("t1 runsDone", {16'b0, runsDone}, 3);
    checkValue("t1 failCount", {16'b0, failCount}, 0);
    checkValue("t1 doRun pulses", doRunRises - riseBase, 3);
    checkValue("t1 batchDone pulses", batchDonePulses - pulseBase, 1);
    checkValue("t1 gap >= 4", {31'b0, minLowGap >= 4}, 1);
    checkValue("t1 doRun width", lastHighLen, 1);
    // failures latch only the first error instruction
    failMask = 8'b10;
    failInstr = 32'h2A;
    batchBase = doRunRises;
    issueCmd(OP_START, 16'd2);
    waitIdle("t2a");
    @(posedge masterClock);
    #1;
    checkValue("t2a firstErrInstr", firstErrInstr, 32'h2A);
    failMask = 8'b01;
    failInstr = 32'h55;
    batchBase = doRunRises;
    issueCmd(OP_START, 16'd1);
    waitIdle("t2b");
    @(posedge masterClock);
    #1;
    checkValue("t2 failCount", {16'b0, failCount}, 2);
    checkValue("t2 passCount", {16'b0, passCount}, 4);
    checkValue("t2 firstErrInstr", firstErrInstr, 32'h2A);
    checkValue("t2 firstErrValid", {31'b0, firstErrValid}, 1);
    checkValue("t2 runsDone", {16'b0, runsDone}, 1);
    // engine never starts: watchdog timeout
    engineOn = 1'b0;
    failMask = 8'h00;
    pulseBase = batchDonePulses;
    issueCmd(OP_START, 16'd1);
    waitIdle("t3");
    repeat (2) @(posedge masterClock);
    #1;
    checkValue("t3 doRun high cycles", lastHighLen, 16);
    checkValue("t3 timeoutCount", {16'b0, timeoutCount}, 1);
    checkValue("t3 runsDone", {16'b0, runsDone}, 1);
    checkValue("t3 batchDone pulses", batchDonePulses - pulseBase, 1);
    checkValue("t3 failCount", {16'b0, failCount}, 2);
    // abort during second WAIT_DONE
    engineOn = 1'b1;
    batchBase = doRunRises;
    riseBase = doRunRises;
    pulseBase = batchDonePulses;
    issueCmd(OP_START, 16'd5);
    n = 0;
    do begin
      @(posedge masterClock);
      #1;
      n++;
    end while (!(doRunRises - riseBase == 2 && isRunning) && n < 500);
    checkValue("t4 reached second run", doRunRises - riseBase, 2);
    issueCmd(OP_ABORT, 16'd0);
    checkValue("t4 doRun", {31'b0, doRun}, 0);
    checkValue("t4 busy", {31'b0, busy}, 0);
    checkValue("t4 batchDone", {31'b0, batchDone}, 1);
    checkValue("t4 runsDone", {16'b0, runsDone}, 1);
    repeat (20) @(posedge masterClock);
    #1;
    checkValue("t4 batchDone pulses", batchDonePulses - pulseBase, 1);
    checkValue("t4 passCount", {16'b0, passCount}, 5);
    checkValue("t4 no more runs", doRunRises - riseBase, 2);
    // empty batch, then clear statistics
    riseBase = doRunRises;
    issueCmd(OP_START, 16'd0);
    checkValue("t5 batchDone at t+1", {31'b0, batchDone}, 1);
    checkValue("t5 busy", {31'b0, busy}, 0);
    issueCmd(OP_CLEAR, 16'd0);
    checkValue("t5 batchDone once", {31'b0, batchDone}, 0);
    checkValue("t5 stats cleared", {16'b0, passCount | failCount | timeoutCount}, 0);
    checkValue("t5 firstErr cleared", {31'b0, firstErrValid} | firstErrInstr, 0);
    checkValue("t5 runsDone kept", {16'b0, runsDone}, 1);
    checkValue("t5 no doRun", doRunRises - riseBase, 0);
    // START held off while busy, then reset mid WAIT_DONE
    issueCmd(OP_START, 16'd2);
    cmdValid = 1'b1;
    cmdOp = OP_START;
    cmdCount = 16'd7;
    #1;
    checkValue("t6 start held off", {31'b0, cmdReady}, 0);
    repeat (3) @(posedge masterClock);
    #1;
    checkValue("t6 still busy", {31'b0, busy}, 1);
    cmdValid = 1'b0;
    cmdOp = OP_ABORT;
    #1;
    checkValue("t6 abort ready", {31'b0, cmdReady}, 1);
    cmdOp = OP_START;
    n = 0;
    while (!(isRunning && busy) && n < 500) begin
      @(posedge masterClock);
      #1;
      n++;
    end
    @(posedge masterClock);
    #1;
    pulseBase = batchDonePulses;
    reset = 1'b0;
    @(posedge masterClock);
    #1;
    checkValue("t6 reset busy", {31'b0, busy}, 0);
    checkValue("t6 reset doRun", {31'b0, doRun}, 0);
    checkValue("t6 reset cmdReady", {31'b0, cmdReady}, 1);
    checkValue("t6 reset runsDone", {16'b0, runsDone}, 0);
    reset = 1'b1;
    repeat (5) @(posedge masterClock);
    #1;
    checkValue("t6 no batchDone", batchDonePulses - pulseBase, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
